// File: rtl/dbus_uart_tx.sv
// dbus_uart_tx: memory-mapped 8N1 UART transmitter with TX FIFO on the data-memory bus
module dbus_uart_tx #(
    parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_wr_en,
    input  logic [31:0] dAddr,
    input  logic [31:0] dWdata,
    input  logic [1:0]  store_size,
    input  logic [1:0]  load_size,
    input  logic [2:0]  funct3,
    output logic [31:0] dRdata,
    output logic        hit,
    output logic        tx,
    output logic        irq
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level;
    logic          ovf, en, irq_en;
    logic [15:0]   bauddiv, baud_cnt, cnt_n;
    logic [2:0]    bitcnt, bitcnt_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n, pop;
    logic [1:0]    sel;
    logic          wr, push, accept, drop, w1c, baud_wr, ctrl_wr;
    logic          empty, full, busy, sx;
    logic [31:0]   status_w, reg_val, ext_val;
    logic          unused;

    assign sel     = dAddr[3:2];
    assign hit     = dAddr[31:4] == BASE_ADDR[31:4];
    assign wr      = hit & d_wr_en;
    assign push    = wr & (sel == 2'd0);
    assign w1c     = wr & (sel == 2'd1) & dWdata[3];
    assign baud_wr = wr & (sel == 2'd2);
    assign ctrl_wr = wr & (sel == 2'd3);
    assign empty   = level == '0;
    assign full    = level == LW'(FIFO_DEPTH);
    assign busy    = state != IDLE;
    assign accept  = push & (~full | pop);
    assign drop    = push & full & ~pop;
    assign unused  = &{1'b0, dAddr[1:0], dWdata[31:16], funct3[1:0]};

    // FIFO storage; contents need no reset because the pointers are cleared
    always_ff @(posedge clk) begin
        if (accept) mem[wr_ptr] <= dWdata[7:0];
    end

    // FIFO pointers, level and sticky overflow (a new drop beats a W1C clear)
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (accept) wr_ptr <= wr_ptr + AW'(1);
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            level <= level + LW'(accept) - LW'(pop);
            ovf   <= drop | (ovf & ~w1c);
        end
    end

    // Control registers; byte stores reach only lane 0 of BAUDDIV
    always_ff @(posedge clk) begin
        if (rst) begin
            bauddiv <= DEFAULT_DIV;
            en      <= 1'b1;
            irq_en  <= 1'b0;
        end else begin
            if (baud_wr) bauddiv[7:0] <= dWdata[7:0];
            if (baud_wr && store_size != 2'b00) bauddiv[15:8] <= dWdata[15:8];
            if (ctrl_wr) {irq_en, en} <= dWdata[1:0];
        end
    end

    // Transmitter next-state: every bit, start and stop included, lasts bauddiv+1 cycles
    always_comb begin
        state_n  = state;
        pop      = 1'b0;
        tx_n     = tx;
        cnt_n    = baud_cnt == 16'd0 ? bauddiv : baud_cnt - 16'd1;
        bitcnt_n = bitcnt;
        shift_n  = shift;
        case (state)
            IDLE: begin
                cnt_n = baud_cnt;
                if (en && !empty) begin
                    pop     = 1'b1;
                    shift_n = mem[rd_ptr];
                    cnt_n   = bauddiv;
                    tx_n    = 1'b0;
                    state_n = START;
                end
            end
            START: begin
                if (baud_cnt == 16'd0) begin
                    tx_n     = shift[0];
                    bitcnt_n = 3'd0;
                    state_n  = DATA;
                end
            end
            DATA: begin
                if (baud_cnt == 16'd0) begin
                    tx_n     = bitcnt == 3'd7 ? 1'b1 : shift[1];
                    shift_n  = shift >> 1;
                    bitcnt_n = bitcnt + 3'd1;
                    state_n  = bitcnt == 3'd7 ? STOP : DATA;
                end
            end
            STOP: begin
                if (baud_cnt == 16'd0) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    // Transmitter state, line driver and idle interrupt registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            tx       <= 1'b1;
            irq      <= 1'b0;
            baud_cnt <= '0;
            bitcnt   <= '0;
            shift    <= '0;
        end else begin
            state    <= state_n;
            tx       <= tx_n;
            irq      <= irq_en & empty & ~busy;
            baud_cnt <= cnt_n;
            bitcnt   <= bitcnt_n;
            shift    <= shift_n;
        end
    end

    assign status_w = {21'b0, 7'(level), ovf, empty, full, busy};
    assign reg_val  = sel == 2'd0 ? 32'b0 :
                      sel == 2'd1 ? status_w :
                      sel == 2'd2 ? {16'b0, bauddiv} : {30'b0, irq_en, en};
    assign sx       = ~funct3[2];
    assign ext_val  = load_size == 2'b00 ? {{24{sx & reg_val[7]}}, reg_val[7:0]} :
                      load_size == 2'b01 ? {{16{sx & reg_val[15]}}, reg_val[15:0]} : reg_val;
    assign dRdata   = hit ? ext_val : 32'b0;
endmodule

// File: tb/tb_dbus_uart_tx.sv
// tb_dbus_uart_tx: scoreboard bench with a serial-line frame decoder for dbus_uart_tx
module tb_dbus_uart_tx;
    localparam logic [31:0] BASE = 32'h1000_0000;

    logic        clk = 1'b0, rst = 1'b1, d_wr_en = 1'b0;
    logic [31:0] dAddr = BASE, dWdata = '0;
    logic [1:0]  store_size = 2'b10, load_size = 2'b10;
    logic [2:0]  funct3 = 3'b000;
    logic [31:0] dRdata;
    logic        hit, tx, irq;

    int   checks = 0, errors = 0, frames = 0, cyc = 0, cur_div = 3;
    bit   burst = 0;
    logic [7:0] exp_q[$];

    dbus_uart_tx #(.BASE_ADDR(BASE), .FIFO_DEPTH(8), .DEFAULT_DIV(16'd3)) dut (
        .clk(clk), .rst(rst), .d_wr_en(d_wr_en), .dAddr(dAddr), .dWdata(dWdata),
        .store_size(store_size), .load_size(load_size), .funct3(funct3),
        .dRdata(dRdata), .hit(hit), .tx(tx), .irq(irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] status_of(input int lvl, input bit ov, input bit bsy);
        return 32'((lvl << 4) + (ov ? 8 : 0) + (lvl == 0 ? 4 : 0) + (lvl == 8 ? 2 : 0) + (bsy ? 1 : 0));
    endfunction

    task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        dAddr = a; dWdata = d; store_size = sz; d_wr_en = 1'b1;
        @(posedge clk); #1;
        d_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, input logic [1:0] sz, input logic [2:0] f3,
                      output logic [31:0] v, output logic h);
        dAddr = a; load_size = sz; funct3 = f3;
        #1;
        v = dRdata; h = hit;
    endtask

    task automatic chk_rd(input string n, input logic [31:0] a, input logic [1:0] sz,
                          input logic [2:0] f3, input logic [31:0] exp);
        logic [31:0] v; logic h;
        rd(a, sz, f3, v, h);
        check(n, v, exp);
    endtask

    task automatic wait_idle(output bit done);
        logic [31:0] v; logic h;
        done = 0;
        @(posedge clk); #1;
        for (int t = 0; t < 2000 && !done; t++) begin
            rd(BASE + 4, 2'b10, 3'b000, v, h);
            if (v[2] && !v[0]) done = 1;
            else begin @(posedge clk); #1; end
        end
    endtask

    // Monitor: decodes each frame on tx cycle by cycle and scores it against the queue
    initial begin
        logic [9:0] w; bit glitch, aborted, have_prev; int last_end, s;
        have_prev = 0; last_end = 0;
        forever begin
            @(negedge clk);
            if (!burst) have_prev = 0;
            if (!rst && tx === 1'b0) begin
                frames++; s = cyc; glitch = 0; aborted = 0; w = '0;
                if (burst && have_prev) check("gap", s - last_end, 2);
                for (int i = 0; i < 10 && !aborted; i++)
                    for (int j = 0; j <= cur_div && !aborted; j++) begin
                        if (i != 0 || j != 0) @(negedge clk);
                        if (rst) aborted = 1;
                        else if (j == 0) w[i] = tx;
                        else if (tx !== w[i]) glitch = 1;
                    end
                if (!aborted) begin
                    if (exp_q.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_frame: got bits %b expected no frame", w);
                    end else
                        check("frame", {21'b0, glitch, w}, {21'b0, 1'b0, 1'b1, exp_q.pop_front(), 1'b0});
                    last_end = cyc; have_prev = 1;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v, d; logic h; bit done, busy_ok; int n, acc, fr0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_tx", tx, 1);
        check("reset_irq", irq, 0);
        chk_rd("reset_status", BASE + 4, 2'b10, 3'b000, 32'h4);
        chk_rd("reset_baud", BASE + 8, 2'b10, 3'b000, 32'd3);
        chk_rd("reset_ctrl", BASE + 12, 2'b10, 3'b000, 32'h1);
        check("hit_base", hit, 1);

        // single 0xA5 frame with cycle-exact start and busy span
        exp_q.push_back(8'hA5);
        wr(BASE, 32'h0000_00A5, 2'b00);
        chk_rd("a5_level", BASE + 4, 2'b10, 3'b000, status_of(1, 0, 0));
        check("a5_tx_before", tx, 1);
        @(posedge clk); #1;
        check("a5_tx_start", tx, 0);
        busy_ok = 1;
        for (int i = 0; i < 40; i++) begin
            if (i != 0) begin @(posedge clk); #1; end
            rd(BASE + 4, 2'b10, 3'b000, v, h);
            if (!v[0]) busy_ok = 0;
        end
        check("a5_busy40", busy_ok, 1);
        @(posedge clk); #1;
        chk_rd("a5_done", BASE + 4, 2'b10, 3'b000, 32'h4);

        // overflow with en=0, then W1C
        wr(BASE + 12, 32'h0, 2'b10);
        for (int i = 0; i < 9; i++) begin
            d = $urandom;
            if (i < 8) exp_q.push_back(d[7:0]);
            wr(BASE, d, 2'b10);
        end
        chk_rd("ovf_status", BASE + 4, 2'b10, 3'b000, 32'h8A);
        wr(BASE + 4, 32'h8, 2'b10);
        chk_rd("w1c_status", BASE + 4, 2'b10, 3'b000, 32'h82);

        // drain the full FIFO back-to-back with irq enabled
        burst = 1;
        wr(BASE + 12, 32'h3, 2'b10);
        wait_idle(done);
        burst = 0;
        check("drain_done", done, 1);
        check("drain_queue", exp_q.size(), 0);
        chk_rd("drain_status", BASE + 4, 2'b10, 3'b000, 32'h4);
        check("irq_hold", irq, 0);
        @(posedge clk); #1;
        check("irq_rise", irq, 1);

        // randomized rounds: random divisor, random burst length, random store sizes
        for (int r = 0; r < 4; r++) begin
            cur_div = $urandom_range(0, 3);
            wr(BASE + 8, 32'(cur_div), 2'b10);
            wr(BASE + 12, 32'h0, 2'b10);
            n = $urandom_range(1, 11);
            acc = n < 8 ? n : 8;
            for (int i = 0; i < n; i++) begin
                d = $urandom;
                if (i < 8) exp_q.push_back(d[7:0]);
                wr(BASE + 32'($urandom_range(0, 3)), d, 2'($urandom_range(0, 3)));
            end
            chk_rd("rnd_status", BASE + 4, 2'b10, 3'b000, status_of(acc, n > 8, 0));
            wr(BASE + 4, 32'hFFFF_FFFF, 2'b00);
            chk_rd("rnd_w1c", BASE + 4, 2'b10, 3'b000, status_of(acc, 0, 0));
            burst = 1;
            wr(BASE + 12, 32'h1, 2'b10);
            wait_idle(done);
            burst = 0;
            check("rnd_done", done, 1);
            check("rnd_queue", exp_q.size(), 0);
        end

        // BAUDDIV lanes and load extension
        wr(BASE + 8, 32'h0000_1234, 2'b10);
        wr(BASE + 8, 32'hFFFF_FFAB, 2'b00);
        chk_rd("baud_byte_lane", BASE + 8, 2'b10, 3'b000, 32'h12AB);
        wr(BASE + 8, 32'hFFFF_5678, 2'b01);
        chk_rd("baud_half_lane", BASE + 8, 2'b10, 3'b000, 32'h5678);
        wr(BASE + 8, 32'hDEAD_8001, 2'b10);
        chk_rd("lw_baud", BASE + 8, 2'b10, 3'b010, 32'h0000_8001);
        chk_rd("lh_baud", BASE + 8, 2'b01, 3'b001, 32'hFFFF_8001);
        chk_rd("lhu_baud", BASE + 10, 2'b01, 3'b101, 32'h0000_8001);
        chk_rd("lb_baud", BASE + 8, 2'b00, 3'b000, 32'h0000_0001);
        chk_rd("lb_status", BASE + 4, 2'b00, 3'b000, 32'h0000_0004);
        chk_rd("txdata_read", BASE, 2'b10, 3'b000, 32'h0);
        rd(BASE + 32'h10, 2'b10, 3'b000, v, h);
        check("miss_hit", h, 0);
        check("miss_data", v, 0);

        // reset in the middle of a data bit flushes the FIFO and kills the frame
        wr(BASE + 8, 32'd3, 2'b10);
        cur_div = 3;
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'h5A);
        wr(BASE, 32'h3C, 2'b00);
        wr(BASE, 32'h5A, 2'b00);
        repeat (12) @(posedge clk);
        #1 rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check("rst_tx", tx, 1);
        rst = 1'b0;
        fr0 = frames;
        chk_rd("rst_status", BASE + 4, 2'b10, 3'b000, 32'h4);
        chk_rd("rst_ctrl", BASE + 12, 2'b10, 3'b000, 32'h1);
        repeat (80) @(posedge clk);
        #1;
        check("rst_no_frame", frames, fr0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/dbus_uart_tx.md
# dbus_uart_tx

Memory-mapped UART transmitter that responds on the CPU data-memory bus, alongside `data_memory`. The core issues ordinary loads and stores; this block decodes its 16-byte window, queues store bytes in a FIFO, and serialises them as 8N1 frames on `tx`. Its read path returns register contents, sized and extended to match the memory load semantics.

## Interface
- `BASE_ADDR`, 32'h1000_0000: window base; occupies BASE_ADDR..BASE_ADDR+0xF, 16-byte aligned.
- `FIFO_DEPTH`, 8: TX FIFO entries; power of 2, 2..64.
- `DEFAULT_DIV`, 16'd867: BAUDDIV reset value; 100 MHz / 115200.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `d_wr_en` in 1: store strobe from the core.
- `dAddr` in 32: byte address. `dAddr[3:2]` selects the register. `dAddr[1:0]` is ignored.
- `dWdata` in 32: store data.
- `store_size` in 2: 00 byte (lane 0), 01 half (lanes 0-1), 10 word. 11 is treated as word.
- `load_size` in 2: 00 byte, 01 half, 10/11 word.
- `funct3` in 3: load signedness. 000/001 sign-extend; 100/101 zero-extend.
- `dRdata` out 32: combinational read data. It is 0 when `hit`=0.
- `hit` out 1: combinational. High when `dAddr[31:4]==BASE_ADDR[31:4]`. The top muxes `dRdata` with this.
- `tx` out 1: serial output, registered. Idles high.
- `irq` out 1: registered. Equals `CTRL.irq_en & fifo_empty & ~busy`.

## Operation
- Register map (offsets):
  - 0x0 TXDATA, W:
    - A store pushes `dWdata[7:0]`, whatever `store_size` is.
    - A push while full is dropped and sets OVF.
    - Reads return 0.
  - 0x4 STATUS, R/W1C:
    - bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 OVF (sticky), bits[10:4] level (0..FIFO_DEPTH).
    - A write with `dWdata[3]`=1 clears OVF. All other bits are read-only.
  - 0x8 BAUDDIV, R/W, bits[15:0]. Upper bits read as 0. Byte and half stores update only their lanes.
  - 0xC CTRL, R/W:
    - bit0 en, reset 1. bit1 irq_en, reset 0.
    - Clearing en stops new frames from starting; a frame in progress completes.
- Stores take effect only when `hit & d_wr_en`, at the rising edge.
- Read extension:
  - Byte load: register bits[7:0], sign- or zero-extended per `funct3`.
  - Half load: bits[15:0], sign- or zero-extended per `funct3`.
  - Word load: full register.
- FIFO:
  - Circular buffer with wrapping read and write pointers and a level counter.
  - A push while full is accepted if a pop occurs in the same cycle; level is unchanged.
  - A pop while empty never occurs.
- TX FSM, with `bitcnt` a 3-bit data-bit counter:
  - IDLE: if `en & ~empty`, pop the head into the shift register, load the baud counter from BAUDDIV, drive `tx`=0, go to START.
  - START: when the baud counter reaches 0, reload it, drive `tx`=shift[0], set `bitcnt`=0, go to DATA.
  - DATA: at each baud expiry, shift right and increment `bitcnt`. After bit 7 expires, drive `tx`=1 and go to STOP.
  - STOP: when the baud counter reaches 0, go to IDLE.
- Baud counter:
  - Down-counter loaded from BAUDDIV at every bit start, so each bit lasts BAUDDIV+1 cycles.
  - A BAUDDIV write mid-bit affects only later bits.
  - BAUDDIV=0 gives 1 cycle per bit.
- Frame = 10×(BAUDDIV+1) cycles. One IDLE cycle separates back-to-back frames.

## Timing
- Reset values:
  - `tx`=1, `irq`=0, FSM=IDLE, FIFO empty (level 0), OVF=0.
  - BAUDDIV=DEFAULT_DIV, CTRL=32'h1.
  - `dRdata` and `hit` are combinational, with no reset state.
- Reset asserted mid-frame: `tx`=1 at the next edge and the FIFO is flushed. No partial frame resumes.
- TXDATA store at edge k:
  - Level increments at k.
  - If the FSM is IDLE with en=1, the pop happens and `tx` falls at edge k+1.
  - The start bit covers edges k+1..k+1+BAUDDIV.
- STATUS read in the same cycle as a store reflects pre-edge state.
- OVF set and W1C clear in the same cycle: set wins.
- `irq` updates one edge after its inputs change.

## Test plan
- Reset, BAUDDIV=3: `tx`=1, STATUS reads 0x4, word load of 0x8 = 3, CTRL=1, `irq`=0.
- SB 0xA5 to TXDATA at edge k:
  - `tx`=0 for cycles k+1..k+4.
  - Then 1,0,1,0,0,1,0,1 for 4 cycles each.
  - Then stop bit 1 for 4 cycles.
  - busy stays 1 for all 40 cycles.
- Push 9 bytes with en=0 and depth 8: STATUS = level 8, full, OVF = 0x8A. W1C 0x8 clears OVF only.
- Set en=1 with FIFO full:
  - 8 frames are emitted with a 1-cycle idle gap between them.
  - The final STATUS = 0x4.
  - With irq_en=1, `irq` rises one edge after busy falls.
- Set BAUDDIV=16'h8001:
  - LH of 0x8 = 0xFFFF8001.
  - LHU of 0x8 = 0x00008001.
  - LB of 0x8 = 0x00000001.
  - Load from BASE_ADDR+0x10: `hit`=0, `dRdata`=0.
- Assert `rst` mid-DATA: `tx`=1 next edge, level 0, and no frame follows.
